// File: rtl/taillight_cmd_ctrl.sv
// Turn/hazard command controller for the taillight sequencer: synchronizes the
// switch inputs, paces mode changes on a prescaled lamp step, and auto-cancels turns.
module taillight_cmd_ctrl #(
  parameter int unsigned DIV = 4,
  parameter int unsigned TMO = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       LeftReq,
  input  logic       RightReq,
  input  logic       HazReq,
  output logic [1:0] S,
  output logic       StepEn,
  output logic       Busy,
  output logic       Timeout,
  output logic       Conflict
);

  // Encodings equal the S mode codes, so S is a straight registered copy.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RIGHT  = 2'b01,
    ST_LEFT   = 2'b10,
    ST_HAZARD = 2'b11
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
  localparam logic [7:0]  TC_LAST  = 8'(TMO - 1);

  state_t      state_q, state_d;
  logic [1:0]  s_q, s_d;
  logic [1:0]  l_sync_q, l_sync_d;
  logic [1:0]  r_sync_q, r_sync_d;
  logic [1:0]  h_sync_q, h_sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tc_q, tc_d;
  logic        lock_l_q, lock_l_d;
  logic        lock_r_q, lock_r_d;
  logic        timeout_q, timeout_d;
  logic        conflict_q, conflict_d;
  logic        step, l, r, h;

  assign l    = l_sync_q[1];
  assign r    = r_sync_q[1];
  assign h    = h_sync_q[1];
  assign step = (cnt_q == CNT_LAST);

  always_comb begin
    l_sync_d   = {l_sync_q[0], LeftReq};
    r_sync_d   = {r_sync_q[0], RightReq};
    h_sync_d   = {h_sync_q[0], HazReq};
    cnt_d      = step ? 16'd0 : cnt_q + 16'd1;
    state_d    = state_q;
    tc_d       = tc_q;
    lock_l_d   = lock_l_q;
    lock_r_d   = lock_r_q;
    conflict_d = 1'b0;
    if (step) begin
      if (lock_l_q && !l) lock_l_d = 1'b0;
      if (lock_r_q && !r) lock_r_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (h) begin
            state_d = ST_HAZARD;
          end else if (l && r) begin
            conflict_d = 1'b1;
          end else if (l && !lock_l_q) begin
            state_d = ST_LEFT;
            tc_d    = 8'd0;
          end else if (r && !lock_r_q) begin
            state_d = ST_RIGHT;
            tc_d    = 8'd0;
          end
        end
        ST_LEFT: begin
          if (h) begin
            state_d = ST_HAZARD;
          end else if (!l || r) begin
            state_d = ST_IDLE;
          end else if (tc_q == TC_LAST) begin
            state_d  = ST_IDLE;
            lock_l_d = 1'b1;
          end else begin
            tc_d = tc_q + 8'd1;
          end
        end
        ST_RIGHT: begin
          if (h) begin
            state_d = ST_HAZARD;
          end else if (!r || l) begin
            state_d = ST_IDLE;
          end else if (tc_q == TC_LAST) begin
            state_d  = ST_IDLE;
            lock_r_d = 1'b1;
          end else begin
            tc_d = tc_q + 8'd1;
          end
        end
        default: begin
          if (!h) state_d = ST_IDLE;
        end
      endcase
    end
    timeout_d = lock_l_d | lock_r_d;
    s_d       = state_d;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      s_q        <= 2'b00;
      l_sync_q   <= 2'b00;
      r_sync_q   <= 2'b00;
      h_sync_q   <= 2'b00;
      cnt_q      <= 16'd0;
      tc_q       <= 8'd0;
      lock_l_q   <= 1'b0;
      lock_r_q   <= 1'b0;
      timeout_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      l_sync_q   <= l_sync_d;
      r_sync_q   <= r_sync_d;
      h_sync_q   <= h_sync_d;
      cnt_q      <= cnt_d;
      tc_q       <= tc_d;
      lock_l_q   <= lock_l_d;
      lock_r_q   <= lock_r_d;
      timeout_q  <= timeout_d;
      conflict_q <= conflict_d;
    end
  end

  assign S        = s_q;
  assign StepEn   = step;
  assign Busy     = |s_q;
  assign Timeout  = timeout_q;
  assign Conflict = conflict_q;

endmodule

// File: tb/tb_taillight_cmd_ctrl.sv
// Randomized bench for taillight_cmd_ctrl: a step-level behavioural model of the
// turn/hazard rules is compared against the outputs every cycle.
module tb_taillight_cmd_ctrl;
  localparam int DIV = 4;
  localparam int TMO = 4;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic       LeftReq = 1'b0;
  logic       RightReq = 1'b0;
  logic       HazReq = 1'b0;
  logic [1:0] S;
  logic       StepEn, Busy, Timeout, Conflict;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  taillight_cmd_ctrl #(.DIV(DIV), .TMO(TMO)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .LeftReq(LeftReq), .RightReq(RightReq), .HazReq(HazReq),
    .S(S), .StepEn(StepEn), .Busy(Busy), .Timeout(Timeout), .Conflict(Conflict)
  );

  always #5 Clk = ~Clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: mode is the S code, steps counts lamp steps shown in the current turn.
  int m_phase, m_mode, m_steps;
  bit m_lock_l, m_lock_r, m_conf;
  bit ml[2], mr[2], mh[2];

  always @(posedge Clk or negedge Rst_n) begin
    bit l, r, h;
    if (!Rst_n) begin
      m_phase = 0; m_mode = 0; m_steps = 0;
      m_lock_l = 0; m_lock_r = 0; m_conf = 0;
      ml = '{0, 0}; mr = '{0, 0}; mh = '{0, 0};
    end else begin
      l = ml[1]; r = mr[1]; h = mh[1];
      m_conf = 0;
      if (m_phase == DIV - 1) begin
        if (m_lock_l && !l) m_lock_l = 0;
        if (m_lock_r && !r) m_lock_r = 0;
        if (h) m_mode = 3;
        else if (m_mode == 3) m_mode = 0;
        else if (m_mode == 0) begin
          if (l && r) m_conf = 1;
          else if (l && !m_lock_l) begin m_mode = 2; m_steps = 1; end
          else if (r && !m_lock_r) begin m_mode = 1; m_steps = 1; end
        end else begin
          // own request still alone: keep going until TMO steps have been shown
          if ((m_mode == 2) ? (l && !r) : (r && !l)) begin
            if (m_steps == TMO) begin
              if (m_mode == 2) m_lock_l = 1; else m_lock_r = 1;
              m_mode = 0;
            end else m_steps++;
          end else m_mode = 0;
        end
      end
      ml[1] = ml[0]; ml[0] = LeftReq;
      mr[1] = mr[0]; mr[0] = RightReq;
      mh[1] = mh[0]; mh[0] = HazReq;
      m_phase = (m_phase + 1) % DIV;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk_val("S", 32'(S), 32'(m_mode));
      chk_val("StepEn", 32'(StepEn), 32'(m_phase == DIV - 1));
      chk_val("Busy", 32'(Busy), 32'(m_mode != 0));
      chk_val("Timeout", 32'(Timeout), 32'(m_lock_l | m_lock_r));
      chk_val("Conflict", 32'(Conflict), 32'(m_conf));
    end
  end

  task automatic drive(input bit l, input bit r, input bit h, input int cycles);
    LeftReq = l; RightReq = r; HazReq = h;
    repeat (cycles) @(negedge Clk);
  endtask

  initial begin
    int found;
    int sel;
    #2 Rst_n = 1'b0;
    #1;
    chk_val("rst_S", 32'(S), 32'd0);
    chk_val("rst_StepEn", 32'(StepEn), 32'd0);
    chk_val("rst_Timeout", 32'(Timeout), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    chk_en = 1'b1;

    // idle pacing, then timeout, hazard override, reversal and conflict
    drive(0, 0, 0, 20);
    drive(1, 0, 0, 40);
    drive(0, 0, 0, 12);
    drive(1, 0, 0, 9);
    drive(1, 0, 1, 10);
    drive(1, 0, 0, 14);
    drive(0, 1, 0, 14);
    drive(1, 1, 0, 16);
    drive(0, 1, 0, 40);
    drive(1, 0, 0, 12);
    drive(0, 0, 0, 8);

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: drive(1, 0, 0, $urandom_range(1, 30));
        3, 4, 5: drive(0, 1, 0, $urandom_range(1, 30));
        6:       drive(1, 1, 0, $urandom_range(1, 12));
        7:       drive($urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom_range(1, 15));
        default: drive(0, 0, 0, $urandom_range(1, 10));
      endcase
    end

    // asynchronous reset in the middle of a right turn
    drive(0, 0, 0, 12);
    RightReq = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge Clk);
      if (S == 2'b01) found = 1;
    end
    chk_val("reach_right", 32'(found), 32'd1);
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk_val("async_S", 32'(S), 32'd0);
    chk_val("async_Busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    RightReq = 1'b0;
    Rst_n = 1'b1;
    drive(0, 1, 0, 30);
    drive(0, 0, 0, 10);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
